// File: rtl/leg_pkg.sv
// Shared LEG execute-path definitions: register numbering, multiplier FSM
// state encoding and MUL/UMULH mode select values.
package leg_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] XZR_REG = REG_ADDR_W'(31);

    localparam logic MODE_MUL   = 1'b0;
    localparam logic MODE_UMULH = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage : leg_pkg

// File: rtl/mul_step.sv
// One radix-2 shift-add step of the iterative multiplier.
// Ports:
//   a_i       multiplicand
//   p_i       current 2*WIDTH partial-product/multiplier register
//   p_next_c  product register after one add-and-shift step (combinational)
module mul_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [2*WIDTH-1:0] p_i,
    output logic [2*WIDTH-1:0] p_next_c
);

    logic [WIDTH:0] sum;

    // Add A into the upper half when the current multiplier LSB is set; the
    // carry bit is kept so the right shift loses nothing.
    always_comb begin
        sum      = {1'b0, p_i[2*WIDTH-1:WIDTH]} + (p_i[0] ? {1'b0, a_i} : '0);
        p_next_c = {sum, p_i[WIDTH-1:1]};
    end

endmodule : mul_step

// File: rtl/iter_multiplier.sv
// Multi-cycle unsigned shift-add multiplier (MUL / UMULH) returning its
// result to the register file through a write/grant handshake.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, mode       request (sampled while ready) and MUL/UMULH select
//   opA, opB          multiplicand / multiplier
//   destRegIn         destination register (XZR requests are dropped)
//   abort             pipeline flush, cancels an operation in RUN or DONE
//   wbGrant           writeback port granted this cycle
//   ready, busy       decoded from the registered state
//   write, writeReg,
//   writeData         registered writeback request
module iter_multiplier
    import leg_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      opA,
    input  logic [WIDTH-1:0]      opB,
    input  logic [REG_ADDR_W-1:0] destRegIn,
    input  logic                  abort,
    input  logic                  wbGrant,
    output logic                  ready,
    output logic                  busy,
    output logic                  write,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [WIDTH-1:0]      writeData
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    mul_state_t            state_q, state_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [2*WIDTH-1:0]    p_q, p_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic                  write_q, write_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [WIDTH-1:0]      write_data_q, write_data_d;
    logic [2*WIDTH-1:0]    p_next_c;

    mul_step #(.WIDTH(WIDTH)) u_mul_step (
        .a_i      (a_q),
        .p_i      (p_q),
        .p_next_c (p_next_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            p_q          <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            dest_q       <= '0;
            write_q      <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            p_q          <= p_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            dest_q       <= dest_d;
            write_q      <= write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    // Next-state and output logic; writeback outputs are produced on the
    // final RUN step so they are already registered on entry to DONE.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        p_d          = p_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        dest_d       = dest_q;
        write_d      = write_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;

        case (state_q)
            IDLE: begin
                // Flush beats start; writes to XZR are discarded at issue.
                if (start && !abort && (destRegIn != XZR_REG)) begin
                    a_d     = opA;
                    mode_d  = mode;
                    dest_d  = destRegIn;
                    p_d     = {WIDTH'(0), opB};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    p_d   = p_next_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d      = DONE;
                        write_d      = 1'b1;
                        write_reg_d  = dest_q;
                        write_data_d = (mode_q == MODE_UMULH) ? p_next_c[2*WIDTH-1:WIDTH]
                                                              : p_next_c[WIDTH-1:0];
                    end
                end
            end
            DONE: begin
                // Hold the request until granted or flushed.
                if (abort || wbGrant) begin
                    state_d = IDLE;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
            end
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign write     = write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;

endmodule : iter_multiplier

// File: doc/iter_multiplier.md
Name: iter_multiplier

Overview:
- Multi-cycle 64-bit unsigned shift-add multiplier in the LEG CPU execute path.
- Consumes the two register-file read operands and the destination register number.
- Returns the result to the register file's single write port through a write/grant handshake.
- Implements MUL (low 64 bits of the product) and UMULH (high 64 bits of the product).

Parameters:
- WIDTH, 64, operand/result width in bits.
- REG_ADDR_W, 5, register-number width (32 architectural registers; register 31 is XZR).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request; sampled only while ready=1.
- mode  in  1  0 = MUL (low half), 1 = UMULH (high half).
- opA  in  WIDTH  multiplicand (readDataA).
- opB  in  WIDTH  multiplier (readDataB).
- destRegIn  in  REG_ADDR_W  destination register number.
- abort  in  1  pipeline flush; cancels the operation in flight.
- wbGrant  in  1  writeback port granted this cycle.
- ready  out  1  unit idle and able to accept start.
- busy  out  1  operation in RUN or DONE.
- write  out  1  write request to the register file.
- writeReg  out  REG_ADDR_W  register number to write.
- writeData  out  WIDTH  result to write.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ready=1, busy=0, write=0.
  - writeReg=0, writeData=0; internal product, counter, mode and destination registers all cleared.
  - Reset asserted mid-operation discards the operation; no write ever occurs for it.
- States: IDLE, RUN, DONE. ready = (state==IDLE); busy = (state!=IDLE).
- IDLE:
  - On start=1, latch A=opA, mode and dest=destRegIn.
  - Load the 2*WIDTH product register P as {WIDTH'0, opB} and set cnt=0.
  - If destRegIn==31 (XZR), stay in IDLE and do not latch; ready stays 1 and no write is produced.
  - Otherwise go to RUN.
- RUN, one step per cycle:
  - sum = {1'b0, P[2W-1:W]} + (P[0] ? A : 0), computed WIDTH+1 bits wide.
  - P <= {sum, P[W-1:1]}, i.e. a right shift including the carry bit.
  - cnt <= cnt+1. After the WIDTH-th step (cnt==WIDTH-1), go to DONE.
  - Counter width is clog2(WIDTH)+1.
- DONE:
  - write=1, writeReg=dest.
  - writeData = mode ? P[2W-1:W] : P[W-1:0].
  - Outputs are held stable until wbGrant=1. In the grant cycle the register file captures the data; on the next edge go to IDLE with write=0.
- Latency:
  - Start sampled at edge E0.
  - write first high in the cycle following edge E0+WIDTH, i.e. WIDTH+1 cycles after the start cycle with immediate grant.
  - Next start can be accepted in the cycle after the grant cycle.
- start while busy is ignored; it is neither queued nor errored.
- abort=1 in RUN or DONE moves to IDLE on the next edge. write drops in that next cycle, and no write is ever granted for the aborted operation.
- abort and wbGrant in the same cycle: abort wins. The unit still leaves via IDLE. The design guarantees the grant is not honoured downstream, because the writeback arbiter also sees the flush.
- abort in IDLE has no effect. abort and start together in IDLE: abort wins, start is dropped.
- write is only ever high in DONE, so writeData/writeReg are don't-care to the register file whenever write=0. They are nevertheless held at their last values, not cleared.
- Outputs are registered; no combinational path from inputs to write/writeData/writeReg. ready/busy are decoded from registered state.

Decomposition:
- leg_pkg holds:
  - REG_ADDR_W and XZR_REG=31.
  - Typedef mul_state_t {IDLE, RUN, DONE}.
  - Constants MODE_MUL=0 and MODE_UMULH=1.
- One natural sub-module: mul_step.
  - Combinational: takes A and P, returns the next P (add + shift).
  - Isolated so a radix-4 variant can replace it later without touching the FSM.

Test Plan:
- MUL 3×5, dest=7, wbGrant tied 1 -> write=1 exactly 65 cycles after the start cycle, writeReg=7, writeData=15, write high for one cycle, ready=1 the next cycle.
- UMULH 0xFFFF_FFFF_FFFF_FFFF×2 -> writeData=1. Repeat with MUL -> writeData=0xFFFF_FFFF_FFFF_FFFE.
- MUL and UMULH of 2^32×2^32 -> MUL writeData=0, UMULH writeData=1. Then 0×0xDEAD -> writeData=0.
- wbGrant held 0 for 3 cycles in DONE -> write, writeReg and writeData stable for 4 cycles, then IDLE after the grant. A start pulse with opA=9 during RUN is ignored and the original result is unchanged.
- abort at cycle 20 of RUN -> IDLE next cycle, no write ever asserted. destRegIn=31 start -> ready stays 1, write never asserted.
- rst pulled low asynchronously mid-RUN (between edges) -> ready=1, busy=0, write=0 immediately, without waiting for a clock edge. After release, a new 6×7 MUL produces 42.
